// File: rtl/start_conditioner_pkg.sv
// start_conditioner_pkg
//   Shared definitions for the start-request conditioner: FSM state
//   encoding (3-bit, S_IDLE=0 .. S_DB_REL=4) and the default debounce
//   window and counter width.
package start_conditioner_pkg;

    localparam int unsigned DB_CYCLES_DEFAULT = 500000;
    localparam int unsigned CNT_W_DEFAULT     = 19;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DB_PRESS = 3'd1,
        S_FIRE     = 3'd2,
        S_BUSY     = 3'd3,
        S_DB_REL   = 3'd4
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for signals asynchronous to clk. Reusable for
//   any external input; both stages reset to 0.
// Ports:
//   clk   - destination clock
//   reset - asynchronous active-high reset
//   d     - asynchronous input
//   q     - synchronized output (two clk edges of latency)
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/start_conditioner.sv
// start_conditioner
//   Turns a raw bouncing push-button into a single-cycle start pulse for
//   the control unit, locks out further requests until the control unit
//   reports completion and the button has been released and debounced,
//   and counts issued start pulses.
//
//   Build option START_DEBOUNCE_EN:
//     defined   - press/release must be stable for DB_CYCLES cycles.
//     undefined - no debounce counter; one stable cycle suffices
//                 (fast simulation). DB_CYCLES/CNT_W are then unused.
//
// Ports:
//   clk     - system clock, rising edge
//   reset   - asynchronous active-high reset
//   btn     - raw push-button, asynchronous, active-high
//   fin     - completion flag from the control unit (honoured only in S_BUSY)
//   xs      - start pulse, exactly one cycle wide
//   busy    - high while a started operation has not reported fin
//   req_cnt - number of xs pulses issued, wraps 255 -> 0
module start_conditioner
    import start_conditioner_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int unsigned CNT_W     = CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    input  logic       fin,
    output logic       xs,
    output logic       busy,
    output logic [7:0] req_cnt
);

    // Named block only appears in the elaborated hierarchy when the
    // counter is too narrow for the window or the window is empty.
    if (DB_CYCLES < 1 || (CNT_W < 32 && (64'd1 << CNT_W) < 64'(DB_CYCLES))) begin : g_cfg_bad
    end

    logic btn_s;

    sync_2ff #(.WIDTH(1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn),
        .q     (btn_s)
    );

    state_t     state_q, state_d;
    logic [7:0] req_cnt_q, req_cnt_d;
    logic       win_done;

`ifdef START_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt counts consecutive qualifying cycles in the two debounce states
    // (btn_s high while pressing, low while releasing); any other state or
    // a wrong-level sample clears it, so a glitch restarts the window.
    always_comb begin
        cnt_d = '0;
        if ((state_q == S_DB_PRESS && btn_s) || (state_q == S_DB_REL && !btn_s))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign win_done = (cnt_q == CNT_LAST);
`else
    assign win_done = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        req_cnt_d = req_cnt_q;
        case (state_q)
            S_IDLE:     if (btn_s) state_d = S_DB_PRESS;
            S_DB_PRESS: begin
                if (!btn_s)        state_d = S_IDLE;
                else if (win_done) state_d = S_FIRE;
            end
            S_FIRE: begin
                state_d   = S_BUSY;
                req_cnt_d = req_cnt_q + 8'd1;
            end
            S_BUSY:     if (fin) state_d = S_DB_REL;
            S_DB_REL:   if (!btn_s && win_done) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            req_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            req_cnt_q <= req_cnt_d;
        end
    end

    // Moore outputs straight from the state register.
    assign xs      = (state_q == S_FIRE);
    assign busy    = (state_q == S_BUSY);
    assign req_cnt = req_cnt_q;

endmodule
